alu_bit_serializer: RTL and testbench



---
 rtl/alu_bit_serializer.sv | 135 +++++++++++++
 tb/tb_alu_bit_serializer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bit_serializer.sv
// alu_bit_serializer
//   Captures a 32-bit ALU result word over a valid/ready handshake, holds it on
//   the 32:1 bit-select mux data bus, steps the mux select through every bit
//   position and streams the returned mux bit out with valid/ready/last.
//
//   Optional build macro: ALU_SER_PARITY_EN appends one even-parity beat
//   (XOR of the captured word) after the 32 data beats.
//
// Parameters
//   LSB_FIRST : 1 -> select order 0..31, 0 -> select order 31..0
//   WORD_W    : word width, fixed at 32 to match the mux (select is 5 bits)
//
// Ports
//   clk, rst_n             : clock (rising edge), async active-low reset
//   in_valid/in_ready      : word handshake (in_ready high only in IDLE)
//   in_data[31:0]          : ALU result word
//   mux_a[31:0]            : captured word driving mux data input A
//   mux_sel[4:0]           : mux select C
//   mux_y                  : mux output Y (combinational from mux_a/mux_sel)
//   ser_bit/ser_valid/ser_ready/ser_last : serial output stream
//   busy                   : word in flight (state != IDLE)
module alu_bit_serializer #(
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [WORD_W-1:0] mux_a,
  output logic [4:0]        mux_sel,
  input  logic              mux_y,
  output logic              ser_bit,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              busy
);

  localparam int unsigned SEL_W = 5;
  localparam int unsigned CNT_W = 6;
`ifdef ALU_SER_PARITY_EN
  localparam int unsigned LAST_IDX = WORD_W;
`else
  localparam int unsigned LAST_IDX = WORD_W - 1;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WORD_W-1:0]  mux_a_nxt;
  logic [SEL_W-1:0]   mux_sel_nxt;
  logic               ser_bit_nxt, ser_valid_nxt, ser_last_nxt;
  logic               adv;
  logic               last_beat;
  logic               beat_bit;

  // Beat may advance when the output slot is empty or being consumed
  assign adv       = !ser_valid || ser_ready;
  assign last_beat = (cnt == CNT_W'(LAST_IDX));
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);

`ifdef ALU_SER_PARITY_EN
  // Parity beat is taken from the held word, not the mux, so select is free
  assign beat_bit = (cnt == CNT_W'(WORD_W)) ? ^mux_a : mux_y;
`else
  assign beat_bit = mux_y;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mux_a     <= '0;
      mux_sel   <= '0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mux_a     <= mux_a_nxt;
      mux_sel   <= mux_sel_nxt;
      ser_bit   <= ser_bit_nxt;
      ser_valid <= ser_valid_nxt;
      ser_last  <= ser_last_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    mux_a_nxt     = mux_a;
    mux_sel_nxt   = mux_sel;
    ser_bit_nxt   = ser_bit;
    ser_valid_nxt = ser_valid;
    ser_last_nxt  = ser_last;

    case (state)
      IDLE: begin
        if (in_valid) begin
          mux_a_nxt   = in_data;
          cnt_nxt     = '0;
          mux_sel_nxt = LSB_FIRST ? SEL_W'(0) : SEL_W'(WORD_W - 1);
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // Select only moves on advance edges so mux_y always tracks bit cnt
        if (adv) begin
          ser_bit_nxt   = beat_bit;
          ser_valid_nxt = 1'b1;
          ser_last_nxt  = last_beat;
          cnt_nxt       = cnt + CNT_W'(1);
          mux_sel_nxt   = LSB_FIRST ? (mux_sel + SEL_W'(1)) : (mux_sel - SEL_W'(1));
          if (last_beat) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (ser_ready) begin
          ser_valid_nxt = 1'b0;
          ser_last_nxt  = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_bit_serializer.sv
// Directed bench for alu_bit_serializer: one LSB-first and one MSB-first
// instance share all inputs, each with its own behavioural 32:1 mux.
module tb_alu_bit_serializer;

`ifdef ALU_SER_PARITY_EN
  localparam int NB = 33;
`else
  localparam int NB = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        ser_ready = 1'b1;

  logic        in_ready_l, mux_y_l, ser_bit_l, ser_valid_l, ser_last_l, busy_l;
  logic [31:0] mux_a_l;
  logic [4:0]  mux_sel_l;
  logic        in_ready_m, mux_y_m, ser_bit_m, ser_valid_m, ser_last_m, busy_m;
  logic [31:0] mux_a_m;
  logic [4:0]  mux_sel_m;

  assign mux_y_l = mux_a_l[mux_sel_l];
  assign mux_y_m = mux_a_m[mux_sel_m];

  always #5 clk = ~clk;

  alu_bit_serializer #(.LSB_FIRST(1'b1), .WORD_W(32)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .mux_a(mux_a_l), .mux_sel(mux_sel_l), .mux_y(mux_y_l),
    .ser_bit(ser_bit_l), .ser_valid(ser_valid_l), .ser_ready(ser_ready),
    .ser_last(ser_last_l), .busy(busy_l));

  alu_bit_serializer #(.LSB_FIRST(1'b0), .WORD_W(32)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_data(in_data), .mux_a(mux_a_m), .mux_sel(mux_sel_m), .mux_y(mux_y_m),
    .ser_bit(ser_bit_m), .ser_valid(ser_valid_m), .ser_ready(ser_ready),
    .ser_last(ser_last_m), .busy(busy_m));

  int vectors = 0;
  int miscompares = 0;

  // Per-word capture filled by run_word
  logic       bits_l [0:40];
  logic       bits_m [0:40];
  logic       last_l [0:40];
  logic       last_m [0:40];
  logic [4:0] sel_l  [0:40];
  logic [4:0] sel_m  [0:40];
  logic       st_bit [0:4];
  logic       st_val [0:4];
  logic [4:0] st_sel [0:4];
  logic [5:0] st_cnt [0:4];
  int         nbeats, first_valid_edge, done_edge, a_bad, nstall;
  logic [4:0] sel0_l, sel0_m;
  logic       hs_ready, ab_valid, ab_busy, ab_last;

  // Reference bit for beat n of word d
  function automatic logic exp_bit(input logic [31:0] d, input int n, input bit lsb);
    if (n >= 32) return ^d;
    return lsb ? d[n] : d[31-n];
  endfunction

  // Handshake one word, then observe at each falling edge until in_ready returns.
  task automatic run_word(input logic [31:0] data, input bit stall, input int abort_at);
    nbeats = 0; first_valid_edge = -1; done_edge = -1; a_bad = 0; nstall = 0;
    @(negedge clk);
    hs_ready = in_ready_l & in_ready_m;
    in_valid = 1'b1;
    in_data  = data;
    @(posedge clk);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      in_data = ~data;  // keep offering a different word while busy
      if (k == 0) begin sel0_l = mux_sel_l; sel0_m = mux_sel_m; end
      if (in_ready_l) begin done_edge = k; break; end
      if (mux_a_l !== data || mux_a_m !== data) a_bad++;
      if (first_valid_edge < 0 && ser_valid_l) first_valid_edge = k;
      if (abort_at >= 0 && nbeats == abort_at && ser_valid_l) begin
        #2 rst_n = 1'b0;
        #1;
        ab_valid = ser_valid_l | ser_valid_m;
        ab_busy  = busy_l | busy_m;
        ab_last  = ser_last_l | ser_last_m;
        break;
      end
      if (stall && nbeats == 10 && ser_valid_l && nstall < 5) begin
        ser_ready = 1'b0;
        st_bit[nstall] = ser_bit_l;
        st_val[nstall] = ser_valid_l;
        st_sel[nstall] = mux_sel_l;
        st_cnt[nstall] = dut_lsb.cnt;
        nstall++;
      end else begin
        ser_ready = 1'b1;
      end
      if (ser_valid_l && ser_ready && nbeats < 40) begin
        bits_l[nbeats] = ser_bit_l; bits_m[nbeats] = ser_bit_m;
        last_l[nbeats] = ser_last_l; last_m[nbeats] = ser_last_m;
        sel_l[nbeats]  = mux_sel_l;  sel_m[nbeats]  = mux_sel_m;
        nbeats++;
      end
    end
    in_valid  = 1'b0;
    ser_ready = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mux_a_l, mux_sel_l, ser_bit_l, ser_valid_l, ser_last_l, busy_l} !== '0) begin
      miscompares++; $display("FAIL reset_lsb: got a=%h sel=%0d bit=%b v=%b l=%b busy=%b expected all zero",
        mux_a_l, mux_sel_l, ser_bit_l, ser_valid_l, ser_last_l, busy_l);
    end
    vectors++;
    if ({mux_a_m, mux_sel_m, ser_bit_m, ser_valid_m, ser_last_m, busy_m} !== '0) begin
      miscompares++; $display("FAIL reset_msb: got a=%h sel=%0d bit=%b v=%b l=%b busy=%b expected all zero",
        mux_a_m, mux_sel_m, ser_bit_m, ser_valid_m, ser_last_m, busy_m);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({in_ready_l, in_ready_m} !== 2'b11) begin
      miscompares++; $display("FAIL reset_in_ready: got %b expected 11", {in_ready_l, in_ready_m});
    end
  endtask

  task automatic test_lsb_first();
    logic [31:0] d = 32'h8000_0001;
    run_word(d, 1'b0, -1);
    vectors++;
    if (hs_ready !== 1'b1) begin miscompares++; $display("FAIL lsb_hs_ready: got %b expected 1", hs_ready); end
    vectors++;
    if (first_valid_edge != 1) begin miscompares++; $display("FAIL lsb_first_valid: got edge %0d expected 1", first_valid_edge); end
    vectors++;
    if (done_edge != NB + 1) begin miscompares++; $display("FAIL lsb_in_ready_back: got edge %0d expected %0d", done_edge, NB + 1); end
    vectors++;
    if (nbeats != NB) begin miscompares++; $display("FAIL lsb_beats: got %0d expected %0d", nbeats, NB); end
    vectors++;
    if (sel0_l !== 5'd0) begin miscompares++; $display("FAIL lsb_sel_start: got %0d expected 0", sel0_l); end
    vectors++;
    if (a_bad != 0) begin miscompares++; $display("FAIL lsb_mux_a_hold: got %0d changed cycles expected 0", a_bad); end
    for (int n = 0; n < NB && n < nbeats; n++) begin
      vectors++;
      if (bits_l[n] !== exp_bit(d, n, 1'b1) || last_l[n] !== (n == NB - 1)) begin
        miscompares++; $display("FAIL lsb_beat%0d: got bit=%b last=%b expected bit=%b last=%b",
          n, bits_l[n], last_l[n], exp_bit(d, n, 1'b1), (n == NB - 1));
      end
      if (n < 31) begin
        vectors++;
        if (sel_l[n] !== 5'(n + 1)) begin
          miscompares++; $display("FAIL lsb_sel%0d: got %0d expected %0d", n, sel_l[n], n + 1);
        end
      end
    end
  endtask

  task automatic test_msb_first();
    logic [31:0] d = 32'h0000_00F0;
    run_word(d, 1'b0, -1);
    vectors++;
    if (sel0_m !== 5'd31) begin miscompares++; $display("FAIL msb_sel_start: got %0d expected 31", sel0_m); end
    vectors++;
    if (nbeats != NB) begin miscompares++; $display("FAIL msb_beats: got %0d expected %0d", nbeats, NB); end
    for (int n = 0; n < NB && n < nbeats; n++) begin
      vectors++;
      if (bits_m[n] !== exp_bit(d, n, 1'b0) || last_m[n] !== (n == NB - 1)) begin
        miscompares++; $display("FAIL msb_beat%0d: got bit=%b last=%b expected bit=%b last=%b",
          n, bits_m[n], last_m[n], exp_bit(d, n, 1'b0), (n == NB - 1));
      end
      if (n < 31) begin
        vectors++;
        if (sel_m[n] !== 5'(30 - n)) begin
          miscompares++; $display("FAIL msb_sel%0d: got %0d expected %0d", n, sel_m[n], 30 - n);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d = 32'h0000_00F0;
    run_word(d, 1'b1, -1);
    vectors++;
    if (nstall != 5) begin miscompares++; $display("FAIL bp_stall_cycles: got %0d expected 5", nstall); end
    for (int i = 0; i < nstall; i++) begin
      vectors++;
      if (st_bit[i] !== d[10] || st_val[i] !== 1'b1 || st_sel[i] !== 5'd11 || st_cnt[i] !== 6'd11) begin
        miscompares++; $display("FAIL bp_hold%0d: got bit=%b v=%b sel=%0d cnt=%0d expected bit=%b v=1 sel=11 cnt=11",
          i, st_bit[i], st_val[i], st_sel[i], st_cnt[i], d[10]);
      end
    end
    vectors++;
    if (nbeats != NB) begin miscompares++; $display("FAIL bp_beats: got %0d expected %0d", nbeats, NB); end
    vectors++;
    if (done_edge != NB + 6) begin miscompares++; $display("FAIL bp_in_ready_back: got edge %0d expected %0d", done_edge, NB + 6); end
    for (int n = 0; n < NB && n < nbeats; n++) begin
      vectors++;
      if (bits_l[n] !== exp_bit(d, n, 1'b1) || bits_m[n] !== exp_bit(d, n, 1'b0)) begin
        miscompares++; $display("FAIL bp_beat%0d: got lsb=%b msb=%b expected lsb=%b msb=%b",
          n, bits_l[n], bits_m[n], exp_bit(d, n, 1'b1), exp_bit(d, n, 1'b0));
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] d = 32'hFFFF_FFFF;
    run_word(32'h1234_5678, 1'b0, 16);
    vectors++;
    if ({ab_valid, ab_busy, ab_last} !== 3'b000) begin
      miscompares++; $display("FAIL midrst_outputs: got valid=%b busy=%b last=%b expected 0 0 0", ab_valid, ab_busy, ab_last);
    end
    vectors++;
    if (nbeats != 16) begin miscompares++; $display("FAIL midrst_beats: got %0d expected 16", nbeats); end
    @(negedge clk);
    rst_n = 1'b1;
    run_word(d, 1'b0, -1);
    vectors++;
    if (nbeats != NB) begin miscompares++; $display("FAIL ones_beats: got %0d expected %0d", nbeats, NB); end
    for (int n = 0; n < NB && n < nbeats; n++) begin
      vectors++;
      if (bits_l[n] !== exp_bit(d, n, 1'b1) || bits_m[n] !== exp_bit(d, n, 1'b0) || last_l[n] !== (n == NB - 1)) begin
        miscompares++; $display("FAIL ones_beat%0d: got lsb=%b msb=%b last=%b expected %b %b %b",
          n, bits_l[n], bits_m[n], last_l[n], exp_bit(d, n, 1'b1), exp_bit(d, n, 1'b0), (n == NB - 1));
      end
    end
  endtask

  task automatic test_zero_word();
    run_word(32'h0, 1'b0, -1);
    vectors++;
    if (nbeats != NB) begin miscompares++; $display("FAIL zero_beats: got %0d expected %0d", nbeats, NB); end
    for (int n = 0; n < NB && n < nbeats; n++) begin
      vectors++;
      if (bits_l[n] !== 1'b0 || bits_m[n] !== 1'b0 || last_m[n] !== (n == NB - 1)) begin
        miscompares++; $display("FAIL zero_beat%0d: got lsb=%b msb=%b last=%b expected 0 0 %b",
          n, bits_l[n], bits_m[n], last_m[n], (n == NB - 1));
      end
    end
  endtask

`ifdef ALU_SER_PARITY_EN
  task automatic test_parity();
    run_word(32'h0000_0007, 1'b0, -1);
    vectors++;
    if (bits_l[32] !== 1'b1 || last_l[32] !== 1'b1 || last_l[31] !== 1'b0 || bits_m[32] !== 1'b1) begin
      miscompares++; $display("FAIL parity7: got bit=%b last=%b last31=%b msb=%b expected 1 1 0 1",
        bits_l[32], last_l[32], last_l[31], bits_m[32]);
    end
    run_word(32'h0000_0003, 1'b0, -1);
    vectors++;
    if (bits_l[32] !== 1'b0 || last_l[32] !== 1'b1 || last_l[31] !== 1'b0) begin
      miscompares++; $display("FAIL parity3: got bit=%b last=%b last31=%b expected 0 1 0",
        bits_l[32], last_l[32], last_l[31]);
    end
    vectors++;
    if (done_edge != 34) begin miscompares++; $display("FAIL parity_cycle: got edge %0d expected 34", done_edge); end
  endtask
`endif

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_backpressure();
    test_reset_mid_word();
    test_zero_word();
`ifdef ALU_SER_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
